tcs3200_color_sampler: RTL and testbench
========================================

Name: tcs3200_color_sampler

Overview:
Upstream front-end for the game FSM's 3-bit color input. It drives a TCS3200 color sensor's filter-select pins and counts sensor output pulses per filter over a fixed gate window. It classifies the red/green/blue counts into a 3-bit {R,G,B} code, registered with a one-cycle valid strobe. Runs continuously; the FSM samples color whenever valid is high.

Parameters:
GATE_CYCLES, 50000, clk cycles per counting window (1 ms at 50 MHz)
SETTLE_CYCLES, 500, clk cycles ignored after each filter change
CNT_W, 16, width of each channel counter
THRESH, 100, minimum count for a channel to be considered lit

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
sensor_out  input  1  raw TCS3200 frequency output, asynchronous to clk
s2  output  1  TCS3200 filter select S2
s3  output  1  TCS3200 filter select S3
color  output  3  classified code {R,G,B}; 000 = none
valid  output  1  one-cycle strobe: color updated
busy  output  1  high while a measurement sweep is in progress

Behaviour:
- Reset (reset=0, async): state=SETTLE on red, {s2,s3}=00, color=000, valid=0, busy=1, all counters/timers=0.
- sensor_out passes through a 2-FF synchronizer plus an edge register; a rising edge is sync_q1 & ~sync_q2. The first 3 clk of synchronizer latency after reset produce no edges.
- Channel order and filter select:
  - RED: {s2,s3}=00
  - GREEN: {s2,s3}=11
  - BLUE: {s2,s3}=01
  - 10 (clear) is never driven.
- States, per channel ch:
  - SETTLE: {s2,s3} held for ch. Timer counts SETTLE_CYCLES clk, then the state becomes COUNT with the channel counter cleared.
  - COUNT: lasts exactly GATE_CYCLES clk. Each rising edge increments cnt[ch]. The counter saturates at 2^CNT_W-1 and never wraps. On the last gate cycle, the next state is SETTLE for the next channel, or DECIDE after BLUE.
  - DECIDE (1 clk): compute max = largest of cntR, cntG, cntB. The bit for channel x is 1 iff cnt[x] >= THRESH and 2*cnt[x] >= max. The compare uses CNT_W+1 bits, so there is no overflow. If all counts are < THRESH, the code is 000. The next state is SETTLE/RED.
- Outputs:
  - color is registered on the DECIDE cycle and visible the following cycle; valid=1 for exactly that one cycle.
  - color holds its value between updates.
  - busy=0 only during the valid cycle.
- Sweep period: 3*(SETTLE_CYCLES+GATE_CYCLES)+1 clk.
- Edges arriving during SETTLE or DECIDE are discarded.
- Reset mid-sweep: everything returns to reset values. A partial sweep never produces valid.
- Parameter constraints: SETTLE_CYCLES >= 1, GATE_CYCLES >= 1.

Optional Feature:
Macro COLOR_HYST_EN.
- Defined: the classification from DECIDE is compared against the previous sweep's classification, held in an internal register reset to 000. color/valid update only when two consecutive sweeps agree; otherwise color holds and valid stays 0.
- Undefined: every DECIDE updates color and pulses valid.

Test Plan:
Parameters for all scenarios: GATE_CYCLES=100, SETTLE_CYCLES=4, THRESH=10, CNT_W=8, macro undefined.
- Reset hold/release -> color=000, valid=0, {s2,s3}=00. The first valid arrives 3*(4+100)+1 = 313 clk after release.
- Stimulus: during red, a sensor pulse every 4 clk (25 edges); during green/blue, every 50 clk (2 edges) -> color=100, valid high for one cycle, {s2,s3} sequence 00, 11, 01, 00.
- Stimulus: red 25 edges, green 20 edges, blue 5 edges -> color=110 (40>=25; blue is below THRESH).
- Stimulus: sensor_out held 0 for a full sweep -> color=000 with valid pulsed. Then assert reset mid-COUNT in the next sweep -> no valid, and the sweep restarts at red.
- Saturation: CNT_W=4, a pulse every 2 clk on all channels -> each count=15 with no wrap, color=111.
- COLOR_HYST_EN defined: sweep A classifies as 100, then sweep B as 010 -> no valid. A second 010 sweep -> valid with color=010.

Source files
------------

// File: rtl/tcs3200_color_sampler.sv
// TCS3200 front-end: steps the sensor through red/green/blue filters, counts output edges per gate window
// and classifies the three counts into a {R,G,B} code. Optional macro COLOR_HYST_EN adds two-sweep agreement.
module tcs3200_color_sampler #(
    parameter int unsigned GATE_CYCLES   = 50000,
    parameter int unsigned SETTLE_CYCLES = 500,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned THRESH        = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_out,
    output logic       s2,
    output logic       s3,
    output logic [2:0] color,
    output logic       valid,
    output logic       busy
);

    localparam int unsigned TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LAST   = TW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {ST_SETTLE, ST_COUNT, ST_DECIDE} state_t;
    typedef enum logic [1:0] {CH_RED, CH_GREEN, CH_BLUE} chan_t;

    state_t          state;
    chan_t           chan;
    logic [TW-1:0]   timer;
    logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b;
    logic            sync_q0, sync_q1, sync_q2;
    logic            rise;
    logic [CNT_W:0]  max_rg, max_all;
    logic [2:0]      code;
    logic            accept;

    // sync_q0/sync_q1 form the synchronizer, sync_q2 is the edge-detect history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q0 <= 1'b0;
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q0 <= sensor_out;
            sync_q1 <= sync_q0;
            sync_q2 <= sync_q1;
        end
    end

    assign rise = sync_q1 & ~sync_q2;

    // Compare in CNT_W+1 bits so 2*cnt cannot overflow.
    always_comb begin
        max_rg  = (cnt_r >= cnt_g) ? {1'b0, cnt_r} : {1'b0, cnt_g};
        max_all = ({1'b0, cnt_b} > max_rg) ? {1'b0, cnt_b} : max_rg;
        code    = '0;
        code[2] = (32'(cnt_r) >= THRESH) && ({cnt_r, 1'b0} >= max_all);
        code[1] = (32'(cnt_g) >= THRESH) && ({cnt_g, 1'b0} >= max_all);
        code[0] = (32'(cnt_b) >= THRESH) && ({cnt_b, 1'b0} >= max_all);
    end

`ifdef COLOR_HYST_EN
    logic [2:0] prev_code;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_code <= '0;
        end else if (state == ST_DECIDE) begin
            prev_code <= code;
        end
    end

    assign accept = (code == prev_code);
`else
    assign accept = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_SETTLE;
            chan  <= CH_RED;
            timer <= '0;
            cnt_r <= '0;
            cnt_g <= '0;
            cnt_b <= '0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            color <= '0;
            valid <= 1'b0;
            busy  <= 1'b1;
        end else begin
            valid <= 1'b0;
            busy  <= 1'b1;
            case (state)
                ST_SETTLE: begin
                    if (timer == SETTLE_LAST) begin
                        timer <= '0;
                        state <= ST_COUNT;
                        case (chan)
                            CH_RED:   cnt_r <= '0;
                            CH_GREEN: cnt_g <= '0;
                            default:  cnt_b <= '0;
                        endcase
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_COUNT: begin
                    if (rise) begin
                        case (chan)
                            CH_RED:   if (cnt_r != '1) cnt_r <= cnt_r + CNT_W'(1);
                            CH_GREEN: if (cnt_g != '1) cnt_g <= cnt_g + CNT_W'(1);
                            default:  if (cnt_b != '1) cnt_b <= cnt_b + CNT_W'(1);
                        endcase
                    end
                    if (timer == GATE_LAST) begin
                        timer <= '0;
                        case (chan)
                            CH_RED: begin
                                chan  <= CH_GREEN;
                                state <= ST_SETTLE;
                                s2    <= 1'b1;
                                s3    <= 1'b1;
                            end
                            CH_GREEN: begin
                                chan  <= CH_BLUE;
                                state <= ST_SETTLE;
                                s2    <= 1'b0;
                                s3    <= 1'b1;
                            end
                            default: state <= ST_DECIDE;
                        endcase
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_DECIDE: begin
                    if (accept) begin
                        color <= code;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                    end
                    state <= ST_SETTLE;
                    chan  <= CH_RED;
                    timer <= '0;
                    s2    <= 1'b0;
                    s3    <= 1'b0;
                end
                default: begin
                    state <= ST_SETTLE;
                    chan  <= CH_RED;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcs3200_color_sampler.sv
// Bench for tcs3200_color_sampler: two instances (CNT_W=8 and CNT_W=4) share one stimulus stream;
// a scoreboard holds the expected code and arrival cycle for every sweep.
module tb_tcs3200_color_sampler;

    localparam int SWEEP = 313;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sensor_out = 1'b0;
    logic       s2_a, s3_a, valid_a, busy_a;
    logic       s2_b, s3_b, valid_b, busy_b;
    logic [2:0] color_a, color_b;

    typedef struct {
        logic [2:0] color;
        int         at;
    } exp_t;

    exp_t       sb_a[$];
    exp_t       sb_b[$];
    int         checks = 0;
    int         errors = 0;
    int         pcnt;
    int         sweep_idx = 0;
    logic [2:0] held_a = '0, held_b = '0;
`ifdef COLOR_HYST_EN
    logic [2:0] prev_a = '0, prev_b = '0;
`endif

    always #5 clk = ~clk;

    tcs3200_color_sampler #(.GATE_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(8), .THRESH(10)) dut (
        .clk(clk), .reset(reset), .sensor_out(sensor_out), .s2(s2_a), .s3(s3_a),
        .color(color_a), .valid(valid_a), .busy(busy_a));

    tcs3200_color_sampler #(.GATE_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(4), .THRESH(10)) dut_sat (
        .clk(clk), .reset(reset), .sensor_out(sensor_out), .s2(s2_b), .s3(s3_b),
        .color(color_b), .valid(valid_b), .busy(busy_b));

    // Cycles since reset release: equals 313 at the negedge where the first valid is visible.
    always @(posedge clk or negedge reset) begin
        if (!reset) pcnt <= 0;
        else        pcnt <= pcnt + 1;
    end

    function automatic logic [2:0] classify(input int r, input int g, input int b, input int w);
        int lim, mx;
        int c[3];
        logic [2:0] res;
        lim = (1 << w) - 1;
        c[0] = (r > lim) ? lim : r;
        c[1] = (g > lim) ? lim : g;
        c[2] = (b > lim) ? lim : b;
        mx = c[0];
        if (c[1] > mx) mx = c[1];
        if (c[2] > mx) mx = c[2];
        for (int i = 0; i < 3; i++) res[2-i] = (c[i] >= 10) && (2 * c[i] >= mx);
        return res;
    endfunction

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic v, b;
                logic [2:0] c;
                exp_t e;
                int n;
                v = (i == 0) ? valid_a : valid_b;
                b = (i == 0) ? busy_a : busy_b;
                c = (i == 0) ? color_a : color_b;
                n = (i == 0) ? sb_a.size() : sb_b.size();
                checks++;
                if (b !== !v) begin
                    errors++;
                    $display("FAIL busy[%0d] cycle %0d: got %b want %b", i, pcnt, b, !v);
                end
                if (v === 1'b1) begin
                    if (n == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid[%0d] cycle %0d: color %b, no valid expected", i, pcnt, c);
                    end else begin
                        if (i == 0) e = sb_a.pop_front();
                        else        e = sb_b.pop_front();
                        checks++;
                        if (c !== e.color) begin
                            errors++;
                            $display("FAIL color[%0d]: got %b want %b", i, c, e.color);
                        end
                        checks++;
                        if (pcnt != e.at) begin
                            errors++;
                            $display("FAIL valid_time[%0d]: got cycle %0d want %0d", i, pcnt, e.at);
                        end
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        sensor_out = 1'b0;
        repeat (4) @(negedge clk);
        sb_a.delete();
        sb_b.delete();
        sweep_idx = 0;
        held_a = '0;
        held_b = '0;
`ifdef COLOR_HYST_EN
        prev_a = '0;
        prev_b = '0;
`endif
        reset = 1'b1;
    endtask

    // Pulses rise k = 2+104*ch + m*p, so each edge is counted inside the channel's gate window;
    // extra pulses at k = 0, 103, 207, 310 land in SETTLE/DECIDE and must be ignored.
    task automatic run_sweep(input int nr, input int pr, input int ng, input int pg,
                             input int nb, input int pb, input int len, input bit chk);
        int n[3], p[3];
        logic [2:0] ca, cb;
        logic [1:0] want;
        bit acc_a, acc_b, hi;
        n = '{nr, ng, nb};
        p = '{pr, pg, pb};
        ca = classify(nr, ng, nb, 8);
        cb = classify(nr, ng, nb, 4);
        acc_a = 1'b0;
        acc_b = 1'b0;
        if (len == SWEEP) begin
`ifdef COLOR_HYST_EN
            acc_a = (ca == prev_a);
            acc_b = (cb == prev_b);
            prev_a = ca;
            prev_b = cb;
`else
            acc_a = 1'b1;
            acc_b = 1'b1;
`endif
            if (acc_a) sb_a.push_back('{color: ca, at: SWEEP * (sweep_idx + 1)});
            if (acc_b) sb_b.push_back('{color: cb, at: SWEEP * (sweep_idx + 1)});
        end
        for (int k = 0; k < len; k++) begin
            hi = (k == 0) || (k == 103) || (k == 207) || (k == 310);
            for (int c = 0; c < 3; c++) begin
                int off;
                off = k - (2 + 104 * c);
                if (n[c] > 0 && off >= 0 && (off % p[c]) == 0 && (off / p[c]) < n[c]) hi = 1'b1;
            end
            sensor_out = hi;
            if (chk && (k == 0 || k == 50 || k == 150 || k == 250)) begin
                want = (k < 104) ? 2'b00 : (k < 208) ? 2'b11 : 2'b01;
                checks++;
                if ({s2_a, s3_a} !== want || {s2_b, s3_b} !== want) begin
                    errors++;
                    $display("FAIL filter_sel k=%0d: got %b/%b want %b", k, {s2_a, s3_a}, {s2_b, s3_b}, want);
                end
            end
            if (k == 100) begin
                checks++;
                if (color_a !== held_a || color_b !== held_b) begin
                    errors++;
                    $display("FAIL color_hold: got %b/%b want %b/%b", color_a, color_b, held_a, held_b);
                end
            end
            @(negedge clk);
        end
        if (len == SWEEP) begin
            if (acc_a) held_a = ca;
            if (acc_b) held_b = cb;
            sweep_idx++;
        end
    endtask

    task automatic check_drained(input string name);
        #2;
        checks++;
        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_valid: pending %0d/%0d want 0/0", name, sb_a.size(), sb_b.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            sensor_out = ~sensor_out;
        end
        #1;
        checks++;
        if (color_a !== 3'b000 || valid_a !== 1'b0 || busy_a !== 1'b1 || {s2_a, s3_a} !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: got color=%b valid=%b busy=%b sel=%b want 000 0 1 00",
                     color_a, valid_a, busy_a, {s2_a, s3_a});
        end
        checks++;
        if (color_b !== 3'b000 || valid_b !== 1'b0 || {s2_b, s3_b} !== 2'b00) begin
            errors++;
            $display("FAIL reset_state_sat: got color=%b valid=%b sel=%b want 000 0 00",
                     color_b, valid_b, {s2_b, s3_b});
        end
    endtask

    task automatic test_red_dominant();
        do_reset();
        run_sweep(25, 4, 2, 50, 2, 50, SWEEP, 1'b1);
        run_sweep(25, 4, 2, 50, 2, 50, SWEEP, 1'b1);
        check_drained("red_dominant");
    endtask

    task automatic test_mixed();
        do_reset();
        run_sweep(25, 4, 20, 4, 5, 4, SWEEP, 1'b1);
        run_sweep(5, 4, 20, 4, 25, 4, SWEEP, 1'b0);
        check_drained("mixed");
    endtask

    task automatic test_dark_and_midreset();
        do_reset();
        run_sweep(0, 1, 0, 1, 0, 1, SWEEP, 1'b1);
        run_sweep(25, 4, 25, 4, 25, 4, 150, 1'b0);
        reset = 1'b0;
        #1;
        checks++;
        if (color_a !== 3'b000 || valid_a !== 1'b0 || {s2_a, s3_a} !== 2'b00) begin
            errors++;
            $display("FAIL midsweep_reset: got color=%b valid=%b sel=%b want 000 0 00",
                     color_a, valid_a, {s2_a, s3_a});
        end
        check_drained("dark");
        do_reset();
        run_sweep(25, 4, 2, 50, 2, 50, SWEEP, 1'b1);
        check_drained("restart");
    endtask

    task automatic test_saturation();
        do_reset();
        run_sweep(50, 2, 50, 2, 50, 2, SWEEP, 1'b1);
        run_sweep(50, 2, 0, 1, 0, 1, SWEEP, 1'b0);
        check_drained("saturation");
    endtask

    task automatic test_hysteresis();
        do_reset();
        run_sweep(25, 4, 2, 50, 2, 50, SWEEP, 1'b0);
        run_sweep(2, 50, 25, 4, 2, 50, SWEEP, 1'b0);
        run_sweep(2, 50, 25, 4, 2, 50, SWEEP, 1'b1);
        check_drained("hysteresis");
    endtask

    initial begin
        fork
            monitor_loop();
            begin
                #(10 * 60000);
                $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_red_dominant();
        test_mixed();
        test_dark_and_midreset();
        test_saturation();
        test_hysteresis();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
